// File: rtl/tile_blitter_pkg.sv
// Shared types and constants for the tile blitter: FSM states, pixel byte layout
// and a small width helper.
package tile_blitter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        DONE
    } state_e;

    localparam int BYTES_PER_PX = 3;
    localparam int RGB_W        = 24;

    // Byte index k within a pixel: ROM order is R, G, B
    typedef logic [1:0] byte_idx_t;
    localparam byte_idx_t BYTE_R = 2'd0;
    localparam byte_idx_t BYTE_G = 2'd1;
    localparam byte_idx_t BYTE_B = 2'd2;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_raster_ctr.sv
// Column/row raster counter for one tile, with the linear pixel index
// (row*TILE_W+col) and a flag marking the tile's last pixel.
module tile_raster_ctr
    import tile_blitter_pkg::*;
#(
    parameter int TILE_W = 8,
    parameter int TILE_H = 8,
    parameter int COL_W  = clog2_min1(TILE_W),
    parameter int ROW_W  = clog2_min1(TILE_H),
    parameter int IDX_W  = clog2_min1(TILE_W * TILE_H)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [IDX_W-1:0] idx,
    output logic             last_px
);

    logic col_last;
    logic row_last;

    assign col_last = (col == COL_W'(TILE_W - 1));
    assign row_last = (row == ROW_W'(TILE_H - 1));
    assign last_px  = col_last && row_last;
    assign idx      = IDX_W'(row) * IDX_W'(TILE_W) + IDX_W'(col);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/tile_blitter.sv
// Tile-to-framebuffer blitter: reads R,G,B bytes per pixel from a byte ROM and
// emits raster-ordered pixel writes. Define TILE_BLITTER_TRANSPARENT_EN to skip KEY_RGB pixels.
module tile_blitter
    import tile_blitter_pkg::*;
#(
    parameter int          TILE_W  = 8,
    parameter int          TILE_H  = 8,
    parameter int          COORD_W = 8,
    parameter int          ADDR_W  = 12,
    parameter int          ROM_LAT = 1,
    parameter logic [23:0] KEY_RGB = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  tile_base,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [RGB_W-1:0]   px_rgb
);

    localparam int COL_W = clog2_min1(TILE_W);
    localparam int ROW_W = clog2_min1(TILE_H);
    localparam int IDX_W = clog2_min1(TILE_W * TILE_H);
    localparam int LAT_W = clog2_min1(ROM_LAT + 1);

    state_e             state_q;
    state_e             state_d;
    logic               clear_ctr;
    logic               advance_ctr;
    logic               prime;
    logic               wait_last;
    logic               key_hit;
    logic [LAT_W-1:0]   wait_cnt;
    byte_idx_t          k;
    logic [ADDR_W-1:0]  base_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [7:0]         r_q;
    logic [7:0]         g_q;
    logic [ADDR_W-1:0]  addr_px_cur;
    logic [ADDR_W-1:0]  addr_px_next;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [IDX_W-1:0]   idx;
    logic               last_px;

    tile_raster_ctr #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .IDX_W  (IDX_W)
    ) u_raster (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear_ctr),
        .advance (advance_ctr),
        .col     (col),
        .row     (row),
        .idx     (idx),
        .last_px (last_px)
    );

    assign addr_px_cur  = base_r + ADDR_W'(idx) * ADDR_W'(BYTES_PER_PX);
    assign addr_px_next = addr_px_cur + ADDR_W'(BYTES_PER_PX);
    assign wait_last    = (wait_cnt == LAT_W'(ROM_LAT));

`ifdef TILE_BLITTER_TRANSPARENT_EN
    assign key_hit = ({r_q, g_q, rom_data} == KEY_RGB);
`else
    logic unused_key;
    assign unused_key = ^KEY_RGB;
    assign key_hit    = 1'b0;
`endif

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign px_valid = (state_q == EMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ctr   = 1'b0;
        advance_ctr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    clear_ctr = 1'b1;
                end
            end
            FETCH: begin
                if (!prime && wait_last && (k == BYTE_B)) begin
                    if (!key_hit) begin
                        state_d = EMIT;
                    end else if (last_px) begin
                        state_d = DONE;
                    end else begin
                        advance_ctr = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (px_ready) begin
                    if (last_px) begin
                        state_d = DONE;
                    end else begin
                        advance_ctr = 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The first FETCH cycle (prime) loads the tile's first byte address; afterwards
    // each address is held for ROM_LAT+1 cycles and the next one is preloaded on capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_r   <= '0;
            x_r      <= '0;
            y_r      <= '0;
            k        <= BYTE_R;
            wait_cnt <= '0;
            prime    <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            rom_addr <= '0;
            px_x     <= '0;
            px_y     <= '0;
            px_rgb   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_r   <= tile_base;
                        x_r      <= x_pos;
                        y_r      <= y_pos;
                        k        <= BYTE_R;
                        wait_cnt <= '0;
                        prime    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (prime) begin
                        rom_addr <= addr_px_cur;
                        prime    <= 1'b0;
                        wait_cnt <= '0;
                    end else if (!wait_last) begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                        case (k)
                            BYTE_R: begin
                                r_q      <= rom_data;
                                k        <= BYTE_G;
                                rom_addr <= rom_addr + ADDR_W'(1);
                            end
                            BYTE_G: begin
                                g_q      <= rom_data;
                                k        <= BYTE_B;
                                rom_addr <= rom_addr + ADDR_W'(1);
                            end
                            default: begin
                                k      <= BYTE_R;
                                px_x   <= x_r + COORD_W'(col);
                                px_y   <= y_r + COORD_W'(row);
                                px_rgb <= {r_q, g_q, rom_data};
                                if (key_hit && !last_px) begin
                                    rom_addr <= addr_px_next;
                                end
                            end
                        endcase
                    end
                end
                EMIT: begin
                    if (px_ready && !last_px) begin
                        rom_addr <= addr_px_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_blitter.sv
// Self-checking bench for tile_blitter: a 2x2 tile against a behavioural write-list
// model, directed scenarios (stall, wrap, ignored starts, reset) and random blits.
module tb_tile_blitter;

    localparam int          TILE_W  = 2;
    localparam int          TILE_H  = 2;
    localparam int          NPIX    = TILE_W * TILE_H;
    localparam int          ROM_LAT = 1;
    localparam logic [23:0] KEY_RGB = 24'hFF00FF;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
        logic [11:0] addr;
    } px_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [11:0] tile_base;
    logic [7:0]  x_pos;
    logic [7:0]  y_pos;
    logic        busy;
    logic        done;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic [7:0]  px_x;
    logic [7:0]  px_y;
    logic [23:0] px_rgb;

    logic [7:0]  mem [0:4095];
    logic [7:0]  rom_pipe [ROM_LAT];

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  exp_lat = 0;
    int  stall_cnt = 0;
    int  pix_count = 0;
    int  ready_mode = 0;
    int  stall_px = -1;
    int  stall_left = 0;
    px_t exp_q[$];

    tile_blitter #(
        .TILE_W  (TILE_W),
        .TILE_H  (TILE_H),
        .COORD_W (8),
        .ADDR_W  (12),
        .ROM_LAT (ROM_LAT),
        .KEY_RGB (KEY_RGB)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .tile_base (tile_base),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_rgb    (px_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM with ROM_LAT cycles of read latency
    always @(posedge clk) begin
        rom_pipe[0] <= mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic initMem(input bit rnd);
        for (int a = 0; a < 4096; a++) mem[a] = rnd ? 8'($urandom) : 8'(a);
    endtask

    function automatic px_t modelPixel(input logic [11:0] base, input logic [7:0] x,
                                       input logic [7:0] y, input int idx);
        px_t p;
        logic [11:0] a;
        a      = base + 12'(3 * idx);
        p.x    = x + 8'(idx % TILE_W);
        p.y    = y + 8'(idx / TILE_W);
        p.rgb  = {mem[a], mem[a + 12'd1], mem[a + 12'd2]};
        p.addr = a + 12'd2;
        return p;
    endfunction

    function automatic bit isKeyed(input px_t p);
`ifdef TILE_BLITTER_TRANSPARENT_EN
        return p.rgb == KEY_RGB;
`else
        return (p.rgb != p.rgb);
`endif
    endfunction

    // Builds the expected write list and issues start; with early=1 start is
    // raised during the DONE cycle so it must only be taken in the next IDLE cycle.
    task automatic applyStimulus(input logic [11:0] base, input logic [7:0] x,
                                 input logic [7:0] y, input bit early);
        int keyed;
        px_t p;
        keyed = 0;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            p = modelPixel(base, x, y, i);
            if (isKeyed(p)) keyed++;
            else exp_q.push_back(p);
        end
        exp_lat   = 1 + NPIX * (3 * (ROM_LAT + 1) + 1) - keyed;
        stall_cnt = 0;
        pix_count = 0;
        if (!early) @(negedge clk);
        tile_base = base;
        x_pos     = x;
        y_pos     = y;
        start     = 1'b1;
        if (early) begin
            @(posedge clk);
            #1;
            checkOutput("start_in_done_ignored", busy, 1'b0);
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        tile_base = 12'($urandom);
        x_pos     = 8'($urandom);
        y_pos     = 8'($urandom);
        checkOutput("busy_after_start", busy, 1'b1);
    endtask

    task automatic pokeFetch();
        repeat (3) @(negedge clk);
        start     = 1'b1;
        tile_base = 12'h3FF;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic finishBlit(output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done pulse required one within 4000 cycles");
        end else begin
            lat = cyc - start_cyc;
            checkOutput("done_latency", 64'(lat), 64'(exp_lat + stall_cnt));
            checkOutput("busy_in_done", busy, 1'b1);
            checkOutput("writes_remaining", 64'(exp_q.size()), 64'd0);
        end
    endtask

    task automatic idleCheck();
        @(negedge clk);
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("busy_idle", busy, 1'b0);
        checkOutput("valid_idle", px_valid, 1'b0);
    endtask

    // Drives px_ready and checks every valid cycle against the head of the write list
    always @(negedge clk) begin
        if (!resetn) begin
            px_ready = 1'b1;
        end else begin
            case (ready_mode)
                0: px_ready = 1'b1;
                1: px_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (px_valid && pix_count == stall_px && stall_left > 0) begin
                        px_ready = 1'b0;
                        stall_left--;
                    end else begin
                        px_ready = 1'b1;
                    end
                end
            endcase
            if (px_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got x=%0d y=%0d rgb=%06h required no write",
                             px_x, px_y, px_rgb);
                end else begin
                    checkOutput("px_x", px_x, exp_q[0].x);
                    checkOutput("px_y", px_y, exp_q[0].y);
                    checkOutput("px_rgb", px_rgb, exp_q[0].rgb);
                    checkOutput("rom_addr_hold", rom_addr, exp_q[0].addr);
                    if (!px_ready) begin
                        stall_cnt++;
                    end else begin
                        void'(exp_q.pop_front());
                        pix_count++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int          lat;
        bit          got;
        px_t         p;
        logic [39:0] lit_a [4];
        logic [15:0] lit_w [4];
        logic [11:0] rb;
        logic [7:0]  rx;
        logic [7:0]  ry;

        lit_a[0] = {8'd10, 8'd20, 24'h101112};
        lit_a[1] = {8'd11, 8'd20, 24'h131415};
        lit_a[2] = {8'd10, 8'd21, 24'h161718};
        lit_a[3] = {8'd11, 8'd21, 24'h191A1B};
        lit_w[0] = {8'd255, 8'd255};
        lit_w[1] = {8'd0,   8'd255};
        lit_w[2] = {8'd255, 8'd0};
        lit_w[3] = {8'd0,   8'd0};

        resetn    = 1'b0;
        start     = 1'b0;
        tile_base = '0;
        x_pos     = '0;
        y_pos     = '0;
        initMem(1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_valid", px_valid, 1'b0);
        checkOutput("rst_rom_addr", rom_addr, 12'h000);
        checkOutput("rst_px_x", px_x, 8'd0);
        checkOutput("rst_px_y", px_y, 8'd0);
        checkOutput("rst_px_rgb", px_rgb, 24'h0);
        resetn = 1'b1;

        $display("[TB] basic 2x2 blit");
        for (int i = 0; i < NPIX; i++) begin
            p = modelPixel(12'h010, 8'd10, 8'd20, i);
            checkOutput($sformatf("model_pin%0d", i), {p.x, p.y, p.rgb}, lit_a[i]);
        end
        ready_mode = 0;
        applyStimulus(12'h010, 8'd10, 8'd20, 1'b0);
        finishBlit(lat);
        checkOutput("done_at_29", 64'(lat), 64'd29);
        idleCheck();

        $display("[TB] five-cycle stall on pixel 1");
        ready_mode = 2;
        stall_px   = 1;
        stall_left = 5;
        applyStimulus(12'h010, 8'd10, 8'd20, 1'b0);
        finishBlit(lat);
        checkOutput("done_at_34", 64'(lat), 64'd34);
        checkOutput("stall_cycles", 64'(stall_cnt), 64'd5);
        idleCheck();
        ready_mode = 0;

        $display("[TB] screen wrap");
        for (int i = 0; i < NPIX; i++) begin
            p = modelPixel(12'h010, 8'd255, 8'd255, i);
            checkOutput($sformatf("wrap_pin%0d", i), {p.x, p.y}, lit_w[i]);
        end
        applyStimulus(12'h010, 8'd255, 8'd255, 1'b0);
        finishBlit(lat);
        idleCheck();

        $display("[TB] starts during FETCH and DONE");
        applyStimulus(12'h040, 8'd3, 8'd4, 1'b0);
        pokeFetch();
        finishBlit(lat);
        applyStimulus(12'h080, 8'd50, 8'd60, 1'b1);
        finishBlit(lat);
        idleCheck();

        $display("[TB] reset mid-EMIT");
        applyStimulus(12'h010, 8'd10, 8'd20, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = px_valid;
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL emit_timeout: got no px_valid required one within 200 cycles");
        end
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_rst_valid", px_valid, 1'b0);
        checkOutput("async_rst_busy", busy, 1'b0);
        checkOutput("async_rst_done", done, 1'b0);
        checkOutput("async_rst_rom_addr", rom_addr, 12'h000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        checkOutput("rst_hold_done", done, 1'b0);
        resetn = 1'b1;
        applyStimulus(12'h010, 8'd10, 8'd20, 1'b0);
        finishBlit(lat);
        checkOutput("after_rst_done_at_29", 64'(lat), 64'd29);
        idleCheck();

`ifdef TILE_BLITTER_TRANSPARENT_EN
        $display("[TB] transparent pixel 2");
        mem[12'h016] = 8'hFF;
        mem[12'h017] = 8'h00;
        mem[12'h018] = 8'hFF;
        applyStimulus(12'h010, 8'd10, 8'd20, 1'b0);
        checkOutput("key_write_count", 64'(exp_q.size()), 64'd3);
        finishBlit(lat);
        checkOutput("key_done_at_28", 64'(lat), 64'd28);
        idleCheck();
        initMem(1'b0);
`endif

        $display("[TB] random blits with random backpressure");
        initMem(1'b1);
        ready_mode = 1;
        for (int t = 0; t < 8; t++) begin
            rb = 12'($urandom);
            rx = 8'($urandom);
            ry = 8'($urandom);
            applyStimulus(rb, rx, ry, 1'b0);
            finishBlit(lat);
            idleCheck();
        end
        ready_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_blitter.md
Name: tile_blitter

Overview:
- Parametrised tile-to-framebuffer blitter.
- Fetches a TILE_W x TILE_H tile of 24-bit RGB pixels (3 ROM bytes per pixel: R, G, B) from a byte-wide tile ROM.
- Emits one pixel write per tile pixel, in raster order, to the VGA/framebuffer writer over a valid/ready interface.
- Sits between the game's scene logic (issues start requests) and the VGA adapter write port. Supports ROM latency and writer backpressure.

Parameters:
- TILE_W, 8, tile width in pixels (>=1)
- TILE_H, 8, tile height in pixels (>=1)
- COORD_W, 8, width of the screen x/y coordinates
- ADDR_W, 12, tile ROM byte-address width
- ROM_LAT, 1, ROM read latency in cycles (>=1)
- KEY_RGB, 24'hFF00FF, transparent colour key (used only when the optional feature is compiled in)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request to blit one tile; sampled only in IDLE
- tile_base  in  ADDR_W  ROM byte address of the tile's pixel 0 R byte
- x_pos  in  COORD_W  screen x of the tile's top-left pixel
- y_pos  in  COORD_W  screen y of the tile's top-left pixel
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse after the final pixel handshake
- rom_addr  out  ADDR_W  registered ROM byte address
- rom_data  in  8  ROM read data
- px_valid  out  1  pixel write valid
- px_ready  in  1  writer accepts the pixel when px_valid && px_ready
- px_x  out  COORD_W  pixel screen x
- px_y  out  COORD_W  pixel screen y
- px_rgb  out  24  {R,G,B}

Behaviour:
- Reset (async, resetn low): state=IDLE; busy=0, done=0, px_valid=0; rom_addr, px_x, px_y, px_rgb, counters=0. Reset mid-blit aborts immediately; no done pulse is generated.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE: when start=1, latch tile_base, x_pos and y_pos; clear col, row and byte index k. Go to FETCH. Inputs are not re-sampled until the next IDLE.
- FETCH: rom_addr = base + 3*(row*TILE_W + col) + k, truncated to ADDR_W. rom_addr is held for ROM_LAT+1 cycles; rom_data is captured into byte k on the final edge.
  - k=0 -> R, k=1 -> G, k=2 -> B.
  - After B is captured, go to EMIT.
- EMIT: px_valid=1 with px_x = x + col and px_y = y + row, both mod 2^COORD_W (screen wrap, no saturation). px_rgb = {R,G,B}.
  - px_x, px_y and px_rgb stay stable while px_valid && !px_ready.
  - On handshake: if col==TILE_W-1 && row==TILE_H-1, go to DONE. Otherwise advance raster: col++, or col=0 and row++ at end of row. Set k=0 and return to FETCH.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A start in DONE is ignored; a start in the following IDLE cycle is accepted.
- Throughput with px_ready=1: 3*(ROM_LAT+1)+1 cycles per pixel.
  - Total from start to the done pulse: 1 + TILE_W*TILE_H*(3*(ROM_LAT+1)+1) cycles.
- start while busy: ignored, with no queuing.
- Only one pixel is in flight at a time; no ROM prefetch happens during EMIT stalls.
- px_valid is never asserted outside EMIT.

Optional Feature:
- Macro: TILE_BLITTER_TRANSPARENT_EN.
- Defined: when the captured {R,G,B} equals KEY_RGB, EMIT is skipped. px_valid stays low, the raster advances as if a handshake had occurred, and the cycle count for that pixel is reduced by 1. If the last pixel is keyed, go straight to DONE.
- Undefined: every pixel is emitted and KEY_RGB is unused.

Decomposition:
- Package tile_blitter_pkg holds:
  - state enum (IDLE, FETCH, EMIT, DONE)
  - BYTES_PER_PX=3
  - RGB_W=24
  - byte-index encoding
- Sub-module tile_raster_ctr, parametrised by TILE_W and TILE_H:
  - col/row counters with clear and advance inputs
  - last_px output
  - pixel linear index output (row*TILE_W+col)

Test Plan:
- TILE_W=TILE_H=2, ROM_LAT=1, px_ready=1, tile_base=12'h010, x_pos=10, y_pos=20, ROM[addr]=addr[7:0] -> 4 writes in order (10,20,0x101112), (11,20,0x131415), (10,21,0x161718), (11,21,0x191A1B). done is pulsed exactly 29 cycles after the start edge.
- Same setup, px_ready held low for 5 cycles on pixel 1 -> px_valid, px_x, px_y and px_rgb stay stable for all 5 cycles, rom_addr stays unchanged, and done is delayed by 5 cycles.
- x_pos=255, y_pos=255, COORD_W=8 -> coordinates (255,255), (0,255), (255,0), (0,0).
- start pulsed during FETCH and during DONE -> ignored, with no extra writes. Start in the cycle after DONE is accepted.
- resetn dropped mid-EMIT -> px_valid, busy and done go to 0 asynchronously; a subsequent start blits a full tile from pixel 0.
- With TILE_BLITTER_TRANSPARENT_EN defined and pixel 2 = KEY_RGB -> only 3 writes occur, pixel (10,21) is absent, and done is pulsed one cycle earlier.
